// File: rtl/rv_pkg.sv
// Shared definitions for the load/store path.
// Contents: opcode constants for LOAD/STORE, funct3 size codes, the
// exception-code and LSU state enums, and a byte-enable helper.
package rv_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'b00,
        EXC_MISALIGN = 2'b01,
        EXC_ILLEGAL  = 2'b10,
        EXC_TIMEOUT  = 2'b11
    } exc_code_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE,
        S_ERR
    } state_e;

    // size is funct3[1:0]: 00 byte, 01 half, 10 word. Loads and stores share it.
    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] base;
        case (size)
            2'b00:   base = 4'b0001;
            2'b01:   base = 4'b0011;
            default: base = 4'b1111;
        endcase
        return base << off;
    endfunction

endpackage

// File: rtl/rv_load_align.sv
// Combinational load aligner: moves the addressed byte lane down to bit 0 and
// sign/zero-extends it according to funct3. Shared with any cache fill path.
// Ports:
//   rdata    - raw word from memory
//   byte_off - addr[1:0] of the access
//   funct3   - LB/LH/LW/LBU/LHU
//   data     - extended result
module rv_load_align
    import rv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rdata,
    input  logic [1:0]       byte_off,
    input  logic [2:0]       funct3,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH-1:0] lane;

    assign lane = rdata >> {byte_off, 3'b000};

    always_comb begin
        data = lane;
        case (funct3)
            F3_B:    data = {{(WIDTH-8){lane[7]}}, lane[7:0]};
            F3_H:    data = {{(WIDTH-16){lane[15]}}, lane[15:0]};
            F3_BU:   data = {{(WIDTH-8){1'b0}}, lane[7:0]};
            F3_HU:   data = {{(WIDTH-16){1'b0}}, lane[15:0]};
            default: data = lane;
        endcase
    end

endmodule

// File: rtl/rv_lsu.sv
// Load/store unit. Accepts one LOAD/STORE from execute, runs a req/gnt +
// rvalid data-memory transaction and returns extended load data with a
// one-cycle done pulse (stores complete with done too, no data).
// Ports:
//   clk, rst_n                     - clock, async active-low reset
//   in_valid/in_ready              - op handshake from execute
//   opcode, funct3, addr, wdata    - op fields, captured on accept
//   mem_req/we/be/addr/wdata       - memory request, held stable until gnt
//   mem_gnt, mem_rvalid, mem_rdata - memory responses
//   done, load_data                - completion pulse and load result
//   exc, exc_code                  - exception pulse and cause
module rv_lsu
    import rv_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [3:0]       mem_be,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             done,
    output logic [WIDTH-1:0] load_data,
    output logic             exc,
    output logic [1:0]       exc_code
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_e           state_reg;
    logic [2:0]       funct3_reg;
    logic [1:0]       off_reg;
    logic [CW-1:0]    cnt_reg;

    logic             is_load;
    logic             is_store;
    logic             accept;
    logic             f3_illegal;
    logic             misaligned;
    logic             timeout_hit;
    logic [WIDTH-1:0] aligned;

    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    // Unknown opcodes are simply not accepted, so execute sees no response.
    assign accept   = in_valid & in_ready & (is_load | is_store);

    assign f3_illegal = is_store ? (funct3 > F3_W)
                                 : ((funct3 == 3'b011) || (funct3[2:1] == 2'b11));
    assign misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

    // cnt_reg counts wait cycles already spent in REQ/RESP; the TIMEOUT-th
    // waiting cycle without a response ends the transaction.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == CW'(TIMEOUT - 1));

    rv_load_align #(.WIDTH(WIDTH)) u_align (
        .rdata    (mem_rdata),
        .byte_off (off_reg),
        .funct3   (funct3_reg),
        .data     (aligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            in_ready   <= 1'b1;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= 4'b0000;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            done       <= 1'b0;
            load_data  <= '0;
            exc        <= 1'b0;
            exc_code   <= EXC_NONE;
            funct3_reg <= 3'b000;
            off_reg    <= 2'b00;
            cnt_reg    <= '0;
        end else begin
            done <= 1'b0;
            exc  <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        in_ready   <= 1'b0;
                        funct3_reg <= funct3;
                        off_reg    <= addr[1:0];
                        if (f3_illegal) begin
                            exc       <= 1'b1;
                            exc_code  <= EXC_ILLEGAL;
                            state_reg <= S_ERR;
                        end else if (misaligned) begin
                            exc       <= 1'b1;
                            exc_code  <= EXC_MISALIGN;
                            state_reg <= S_ERR;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_be    <= byte_enable(funct3[1:0], addr[1:0]);
                            mem_addr  <= {addr[WIDTH-1:2], 2'b00};
                            mem_wdata <= wdata << {addr[1:0], 3'b000};
                            cnt_reg   <= '0;
                            state_reg <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        cnt_reg <= '0;
                        if (mem_we) begin
                            done      <= 1'b1;
                            state_reg <= S_DONE;
                        end else begin
                            state_reg <= S_RESP;
                        end
                    end else if (timeout_hit) begin
                        mem_req   <= 1'b0;
                        exc       <= 1'b1;
                        exc_code  <= EXC_TIMEOUT;
                        in_ready  <= 1'b1;
                        state_reg <= S_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                S_RESP: begin
                    if (mem_rvalid) begin
                        load_data <= aligned;
                        done      <= 1'b1;
                        state_reg <= S_DONE;
                    end else if (timeout_hit) begin
                        exc       <= 1'b1;
                        exc_code  <= EXC_TIMEOUT;
                        in_ready  <= 1'b1;
                        state_reg <= S_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                S_DONE, S_ERR: begin
                    in_ready  <= 1'b1;
                    state_reg <= S_IDLE;
                end
                default: begin
                    in_ready  <= 1'b1;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule
